// File: rtl/alu_arbiter.sv
`default_nettype none
// ============================================================================
// Module   : alu_arbiter
// Purpose  : Two-requester arbiter in front of a shared combinational ALU.
//            Define ALU_ARB_ROUND_ROBIN_EN for round-robin contention policy;
//            otherwise req0 has fixed priority.
// Revision : 1.0
// ============================================================================
module alu_arbiter (
  input  logic        clk,
  input  logic        reset_n,
  input  logic        req0_valid,
  input  logic        req1_valid,
  output logic        req0_ready,
  output logic        req1_ready,
  input  logic [15:0] req0_a,
  input  logic [15:0] req0_b,
  input  logic [15:0] req1_a,
  input  logic [15:0] req1_b,
  input  logic [3:0]  req0_op,
  input  logic [3:0]  req1_op,
  input  logic        req0_cin,
  input  logic        req1_cin,
  output logic        rsp_valid,
  input  logic        rsp_ready,
  output logic        rsp_id,
  output logic [15:0] rsp_c,
  output logic [4:0]  rsp_flags,
  output logic [15:0] alu_a,
  output logic [15:0] alu_b,
  output logic [3:0]  alu_op,
  output logic        alu_cin,
  input  logic [15:0] alu_c,
  input  logic [4:0]  alu_flags,
  output logic        busy
);

  typedef enum logic [1:0] {
    IDLE = 2'd0,
    EXEC = 2'd1,
    RESP = 2'd2
  } state_t;

  state_t state;
  logic   grant_id;
  logic   idle_open;
  logic   accept;

`ifdef ALU_ARB_ROUND_ROBIN_EN
  logic last_grant;

  // On contention the requester not served last wins.
  assign grant_id = req1_valid & (~req0_valid | ~last_grant);

  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      last_grant <= 1'b1;
    end else if (accept) begin
      last_grant <= grant_id;
    end
  end
`else
  assign grant_id = req1_valid & ~req0_valid;
`endif

  // Ready is held low while reset is asserted even though state reads IDLE.
  assign idle_open  = (state == IDLE) && reset_n;
  assign req0_ready = idle_open && req0_valid && !grant_id;
  assign req1_ready = idle_open && req1_valid && grant_id;
  assign accept     = req0_ready | req1_ready;

  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      state     <= IDLE;
      busy      <= 1'b0;
      rsp_valid <= 1'b0;
      rsp_id    <= 1'b0;
      rsp_c     <= 16'h0000;
      rsp_flags <= 5'h00;
      alu_a     <= 16'h0000;
      alu_b     <= 16'h0000;
      alu_op    <= 4'h0;
      alu_cin   <= 1'b0;
    end else begin
      case (state)
        IDLE: begin
          if (accept) begin
            state   <= EXEC;
            busy    <= 1'b1;
            rsp_id  <= grant_id;
            alu_a   <= grant_id ? req1_a   : req0_a;
            alu_b   <= grant_id ? req1_b   : req0_b;
            alu_op  <= grant_id ? req1_op  : req0_op;
            alu_cin <= grant_id ? req1_cin : req0_cin;
          end
        end
        EXEC: begin
          state     <= RESP;
          rsp_valid <= 1'b1;
          rsp_c     <= alu_c;
          rsp_flags <= alu_flags;
        end
        RESP: begin
          if (rsp_ready) begin
            state     <= IDLE;
            busy      <= 1'b0;
            rsp_valid <= 1'b0;
          end
        end
        default: begin
          state     <= IDLE;
          busy      <= 1'b0;
          rsp_valid <= 1'b0;
        end
      endcase
    end
  end

endmodule
`default_nettype wire

// File: tb/tb_alu_arbiter.sv
`default_nettype none
// ============================================================================
// Module   : tb_alu_arbiter
// Purpose  : Scoreboard bench for alu_arbiter with an adder ALU stub.
// Revision : 1.0
// ============================================================================
module tb_alu_arbiter;

  logic        clk = 1'b0;
  logic        reset_n;
  logic        req0_valid, req1_valid, req0_ready, req1_ready;
  logic [15:0] req0_a, req0_b, req1_a, req1_b;
  logic [3:0]  req0_op, req1_op;
  logic        req0_cin, req1_cin;
  logic        rsp_valid, rsp_ready, rsp_id;
  logic [15:0] rsp_c;
  logic [4:0]  rsp_flags;
  logic [15:0] alu_a, alu_b, alu_c;
  logic [3:0]  alu_op;
  logic        alu_cin;
  logic [4:0]  alu_flags;
  logic        busy;
  logic [16:0] alu_sum;

  assign alu_sum   = {1'b0, alu_a} + {1'b0, alu_b};
  assign alu_c     = alu_sum[15:0];
  assign alu_flags = {4'b0000, alu_sum[16]};

  always #5 clk = ~clk;

  alu_arbiter dut (
    .clk(clk), .reset_n(reset_n),
    .req0_valid(req0_valid), .req1_valid(req1_valid),
    .req0_ready(req0_ready), .req1_ready(req1_ready),
    .req0_a(req0_a), .req0_b(req0_b), .req1_a(req1_a), .req1_b(req1_b),
    .req0_op(req0_op), .req1_op(req1_op),
    .req0_cin(req0_cin), .req1_cin(req1_cin),
    .rsp_valid(rsp_valid), .rsp_ready(rsp_ready), .rsp_id(rsp_id),
    .rsp_c(rsp_c), .rsp_flags(rsp_flags),
    .alu_a(alu_a), .alu_b(alu_b), .alu_op(alu_op), .alu_cin(alu_cin),
    .alu_c(alu_c), .alu_flags(alu_flags), .busy(busy)
  );

  typedef struct packed {
    logic        id;
    logic [15:0] c;
    logic [4:0]  f;
  } exp_t;

  exp_t exp_q[$];
  exp_t mon_e;
  int   vectors = 0;
  int   miscompares = 0;
  logic last_grant = 1'b1;

  task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
    vectors++;
    if (got !== exp) begin
      miscompares++;
      $display("FAIL %s: got 0x%0h expected 0x%0h at %0t", tag, got, exp, $time);
    end
  endtask

  // Response monitor: a handshake seen here completes on the next rising edge.
  always @(negedge clk) begin
    if (rsp_valid && rsp_ready) begin
      if (exp_q.size() == 0) begin
        check("unexpected_rsp", 32'(rsp_id), 32'hFFFF_FFFF);
      end else begin
        mon_e = exp_q.pop_front();
        check("rsp_id", 32'(rsp_id), 32'(mon_e.id));
        check("rsp_c", 32'(rsp_c), 32'(mon_e.c));
        check("rsp_flags", 32'(rsp_flags), 32'(mon_e.f));
      end
    end
  end

  task automatic drop_reqs();
    req0_valid = 1'b0;
    req1_valid = 1'b0;
  endtask

  // Drive a request, predict the grant, queue the expected response and check
  // accept-edge and EXEC-edge behaviour. Returns one cycle into RESP.
  task automatic send(input logic v0, input logic v1,
                      input logic [15:0] a0, input logic [15:0] b0,
                      input logic [15:0] a1, input logic [15:0] b1,
                      input logic [3:0] op0, input logic [3:0] op1,
                      input logic c0, input logic c1);
    int          n;
    logic        id;
    logic [16:0] sum;
    logic [15:0] ea, eb;
    exp_t        e;
    req0_valid = v0; req1_valid = v1;
    req0_a = a0; req0_b = b0; req1_a = a1; req1_b = b1;
    req0_op = op0; req1_op = op1; req0_cin = c0; req1_cin = c1;
    #1;
    n = 0;
    while (!(req0_ready || req1_ready) && n < 20) begin
      @(negedge clk);
      n++;
    end
    if (n >= 20) begin
      check("grant_timeout", 32'd0, 32'd1);
      return;
    end
`ifdef ALU_ARB_ROUND_ROBIN_EN
    id = (v0 && v1) ? ~last_grant : v1;
`else
    id = v0 ? 1'b0 : 1'b1;
`endif
    check("req0_ready", 32'(req0_ready), 32'(id == 1'b0));
    check("req1_ready", 32'(req1_ready), 32'(id == 1'b1));
    ea  = id ? a1 : a0;
    eb  = id ? b1 : b0;
    sum = {1'b0, ea} + {1'b0, eb};
    e.id = id; e.c = sum[15:0]; e.f = {4'b0000, sum[16]};
    exp_q.push_back(e);
    @(posedge clk); #1;
    last_grant = id;
    check("alu_a", 32'(alu_a), 32'(ea));
    check("alu_b", 32'(alu_b), 32'(eb));
    check("alu_op", 32'(alu_op), 32'(id ? op1 : op0));
    check("alu_cin", 32'(alu_cin), 32'(id ? c1 : c0));
    check("exec_rsp_valid", 32'(rsp_valid), 32'd0);
    check("exec_busy", 32'(busy), 32'd1);
    check("exec_ready", 32'({req0_ready, req1_ready}), 32'd0);
    @(posedge clk); #1;
    check("resp_rsp_valid", 32'(rsp_valid), 32'd1);
    check("resp_busy", 32'(busy), 32'd1);
  endtask

  initial begin
    #200000;
    $display("FAIL watchdog: simulation did not complete");
    $fatal(1, "watchdog");
  end

  initial begin
    reset_n = 1'b0; rsp_ready = 1'b1;
    req0_valid = 1'b1; req1_valid = 1'b0;
    req0_a = 16'h0; req0_b = 16'h0; req1_a = 16'h0; req1_b = 16'h0;
    req0_op = 4'h0; req1_op = 4'h0; req0_cin = 1'b0; req1_cin = 1'b0;
    repeat (2) @(posedge clk);
    #1;
    check("rst_rsp_valid", 32'(rsp_valid), 32'd0);
    check("rst_busy", 32'(busy), 32'd0);
    check("rst_rsp_c", 32'(rsp_c), 32'd0);
    check("rst_alu_a", 32'(alu_a), 32'd0);
    check("rst_ready", 32'({req0_ready, req1_ready}), 32'd0);
    req0_valid = 1'b0;
    @(negedge clk);
    reset_n = 1'b1;

    // Single requester 0, then single requester 1 with carry out.
    send(1'b1, 1'b0, 16'h0003, 16'h0004, 16'h0, 16'h0, 4'h5, 4'h0, 1'b1, 1'b0);
    drop_reqs();
    send(1'b0, 1'b1, 16'h0, 16'h0, 16'hFFFF, 16'h0001, 4'h0, 4'hA, 1'b0, 1'b1);
    drop_reqs();

    // Sustained contention.
    for (int i = 0; i < 4; i++) begin
      send(1'b1, 1'b1, 16'h1000 + 16'(i), 16'h0010, 16'h2000 + 16'(i), 16'h0020,
           4'(i), 4'(15 - i), 1'(i), 1'(i + 1));
    end
    drop_reqs();

    // Response backpressure: outputs hold, requests ignored.
    @(posedge clk); #1;
    rsp_ready = 1'b0;
    send(1'b0, 1'b1, 16'h0, 16'h0, 16'h8000, 16'h8001, 4'h0, 4'h3, 1'b0, 1'b0);
    req0_valid = 1'b1;
    repeat (5) begin
      @(posedge clk); #1;
      check("hold_rsp_valid", 32'(rsp_valid), 32'd1);
      check("hold_rsp_c", 32'(rsp_c), 32'h0001);
      check("hold_rsp_id", 32'(rsp_id), 32'd1);
      check("hold_busy", 32'(busy), 32'd1);
      check("hold_ready", 32'({req0_ready, req1_ready}), 32'd0);
    end
    drop_reqs();
    rsp_ready = 1'b1;
    @(posedge clk); #1;
    check("hold_done_valid", 32'(rsp_valid), 32'd0);
    check("hold_done_busy", 32'(busy), 32'd0);

    // Reset asserted mid-EXEC discards the operation.
    req0_valid = 1'b1; req0_a = 16'h00AA; req0_b = 16'h0055;
    #1;
    check("abort_accept", 32'(req0_ready), 32'd1);
    @(posedge clk); #1;
    req0_valid = 1'b0;
    reset_n = 1'b0;
    #1;
    check("abort_rsp_valid", 32'(rsp_valid), 32'd0);
    check("abort_busy", 32'(busy), 32'd0);
    check("abort_rsp_c", 32'(rsp_c), 32'd0);
    check("abort_rsp_flags", 32'(rsp_flags), 32'd0);
    check("abort_alu_a", 32'(alu_a), 32'd0);
    req1_valid = 1'b1;
    #1;
    check("abort_ready_in_rst", 32'(req1_ready), 32'd0);
    req1_valid = 1'b0;
    repeat (2) @(posedge clk);
    #1;
    check("abort_still_idle", 32'(rsp_valid), 32'd0);
    @(negedge clk);
    reset_n = 1'b1;
    last_grant = 1'b1;
    send(1'b0, 1'b1, 16'h0, 16'h0, 16'h1234, 16'h1111, 4'h0, 4'h7, 1'b0, 1'b1);
    drop_reqs();

    repeat (3) @(posedge clk);
    #1;
    check("sb_drain", 32'(exp_q.size()), 32'd0);
    $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
    $finish;
  end

endmodule
`default_nettype wire
